wf68k30l_movep_bus_seq: RTL and testbench
=========================================

// Module: wf68k30l_movep_bus_seq
// PURPOSE
// - Bus-side byte sequencer for MOVEP: executes the alternate-byte transfers that the control path schedules.
// - Register->memory: splits REG_DATA into big-endian bytes at BASE_ADR+0,+2(,+4,+6).
// - Memory->register: reads the same byte addresses and assembles RESULT.
// - Sits between the control/MOVEP pointer logic and the bus interface; runs one MOVEP at a time.
// PARAMETERS
// - ADR_STEP  2  address increment between byte cycles (MOVEP alternate-byte spacing).
// PORTS
// - Clocking: single clock CLK; synchronous active-high reset RESET_CPU.
// - CLK           in   1   system clock; all state changes on rising edge.
// - RESET_CPU     in   1   synchronous, active-high reset.
// - START         in   1   one-cycle request to begin a MOVEP; sampled only in IDLE.
// - DIR_RD        in   1   1 = memory->register, 0 = register->memory; latched at START.
// - SIZE_LONG     in   1   1 = 4 bytes, 0 = 2 bytes; latched at START.
// - BASE_ADR      in   32  effective address (An+d16); latched at START.
// - REG_DATA      in   32  source register; latched at START.
// - BUS_RDY       in   1   current byte cycle complete.
// - BUS_ERR       in   1   current byte cycle terminated by bus error.
// - BUS_DATA_IN   in   8   read data; valid with BUS_RDY.
// - BUS_REQ       out  1   byte cycle request.
// - BUS_WR        out  1   1 = write cycle; meaningful while BUS_REQ = 1.
// - BUS_ADR       out  32  byte address of the current cycle.
// - BUS_DATA_OUT  out  8   write byte.
// - BYTE_PNTR     out  2   bytes remaining minus one (3..0 long, 1..0 word).
// - RESULT        out  32  assembled register value for reads.
// - BUSY          out  1   high in ACCESS, GAP and FINISH.
// - DONE          out  1   one-cycle pulse at completion.
// - ABORTED       out  1   one-cycle pulse on bus-error abort.
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE.
// - RESET_CPU has priority over every other event, including mid-transfer.
//   - Next cycle: IDLE, BUS_REQ = 0.
//   - The partial transfer is dropped.
// - Four states: IDLE, ACCESS, GAP, FINISH.
// - IDLE, START = 1:
//   - Latch the inputs.
//   - BYTE_PNTR <= 3 (long) or 1 (word); BUS_ADR <= BASE_ADR; BUS_WR <= ~DIR_RD.
//   - Next state ACCESS.
// - ACCESS: BUS_REQ = 1, held stable until BUS_RDY or BUS_ERR.
//   - Write byte: BUS_DATA_OUT = latched data byte BYTE_PNTR, i.e. data[8*BYTE_PNTR+7 : 8*BYTE_PNTR].
//   - BUS_RDY, read: RESULT byte BYTE_PNTR <= BUS_DATA_IN.
//   - BUS_RDY, BYTE_PNTR = 0: next state FINISH.
//   - BUS_RDY, otherwise: BYTE_PNTR -= 1; BUS_ADR += ADR_STEP (mod 2^32, wraps); next state GAP.
// - GAP: BUS_REQ = 0 for exactly one cycle, then ACCESS.
//   - Guarantees back-to-back byte cycles are separated.
// - FINISH: DONE = 1 for one cycle, BUS_REQ = 0, then IDLE.
// - Latency: first BUS_REQ one cycle after START; DONE one cycle after the final BUS_RDY.
// - Word read: RESULT[31:16] <= REG_DATA[31:16] at START, so only the low word is replaced.
// - Long read: all four RESULT bytes are replaced.
// - BUS_ERR in ACCESS:
//   - Takes priority over a simultaneous BUS_RDY.
//   - ABORTED = 1 for one cycle, then IDLE; no DONE.
//   - RESULT keeps the bytes already captured; BUS_REQ drops next cycle.
// - Ignored inputs:
//   - START in any state other than IDLE; the latched operands do not change.
//   - BUS_RDY / BUS_ERR outside ACCESS.
// - RESULT holds its value in IDLE until the next read START.
// - The write path never modifies RESULT.
// TESTING
// - Long write: REG_DATA=0x11223344, BASE=0x1000.
//   -> writes 11@1000, 22@1002, 33@1004, 44@1006; one DONE; 4 BUS_RDY consumed.
// - Word read: REG_DATA=0xAAAA5555, bytes 0x12, 0x34 at 0x2000/0x2002.
//   -> RESULT=0xAAAA1234; DONE one cycle after 2nd BUS_RDY.
// - Wrap: long read at BASE=0xFFFFFFFC.
//   -> addresses FFFFFFFC, FFFFFFFE, 00000000, 00000002.
// - Bus error on 2nd byte of a long read (1st=0x9A).
//   -> ABORTED pulse, no DONE, RESULT[31:24]=0x9A, BUS_REQ low next cycle.
// - Stall: BUS_RDY held low 5 cycles.
//   -> BUS_REQ/BUS_ADR/BUS_DATA_OUT stable; START pulses mid-transfer are ignored.
// - Reset mid-transfer after 1 byte.
//   -> IDLE, all outputs 0 next cycle; a following START runs a clean 4-byte sequence.

Source files
------------

// File: rtl/wf68k30l_movep_bus_seq_if.sv
// Byte-cycle bus between the MOVEP sequencer (master) and the bus interface (slave).
interface wf68k30l_movep_bus_seq_if;
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_adr;
  logic [7:0]  bus_data_out;
  logic        bus_rdy;
  logic        bus_err;
  logic [7:0]  bus_data_in;

  modport master (
    output bus_req, bus_wr, bus_adr, bus_data_out,
    input  bus_rdy, bus_err, bus_data_in
  );

  modport slave (
    input  bus_req, bus_wr, bus_adr, bus_data_out,
    output bus_rdy, bus_err, bus_data_in
  );
endinterface

// File: rtl/wf68k30l_movep_bus_seq.sv
// MOVEP byte sequencer: moves 2 or 4 big-endian register bytes to/from
// alternate byte addresses, one byte cycle at a time.
module wf68k30l_movep_bus_seq #(
  parameter int ADR_STEP = 2
) (
  input  logic        clk,
  input  logic        reset_cpu,
  input  logic        start,
  input  logic        dir_rd,
  input  logic        size_long,
  input  logic [31:0] base_adr,
  input  logic [31:0] reg_data,
  wf68k30l_movep_bus_seq_if.master bus,
  output logic [1:0]  byte_pntr,
  output logic [31:0] result,
  output logic        busy,
  output logic        done,
  output logic        aborted
);

  typedef enum logic [1:0] {IDLE, ACCESS, GAP, FINISH} state_t;

  state_t      state, state_nxt;
  logic [31:0] data_q;
  logic [31:0] adr_q;
  logic        wr_q;
  logic        aborted_q;
  logic [4:0]  byte_sel;

  assign byte_sel = {byte_pntr, 3'b000};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCESS;
      ACCESS: begin
        if (bus.bus_err)      state_nxt = IDLE;
        else if (bus.bus_rdy) state_nxt = (byte_pntr == 2'd0) ? FINISH : GAP;
      end
      GAP:     state_nxt = ACCESS;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_cpu) begin
      state     <= IDLE;
      byte_pntr <= 2'd0;
      adr_q     <= 32'd0;
      wr_q      <= 1'b0;
      result    <= 32'd0;
      aborted_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      aborted_q <= (state == ACCESS) && bus.bus_err;
      case (state)
        IDLE: if (start) begin
          byte_pntr <= size_long ? 2'd3 : 2'd1;
          adr_q     <= base_adr;
          wr_q      <= ~dir_rd;
          // a word read leaves the upper register word untouched
          if (dir_rd && !size_long) result[31:16] <= reg_data[31:16];
        end
        ACCESS: if (!bus.bus_err && bus.bus_rdy) begin
          if (!wr_q) result[byte_sel +: 8] <= bus.bus_data_in;
          if (byte_pntr != 2'd0) begin
            byte_pntr <= byte_pntr - 2'd1;
            adr_q     <= adr_q + 32'(ADR_STEP);
          end
        end
        default: ;
      endcase
    end
  end

  // Operand copy is pure data; its value is irrelevant until the next START.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) data_q <= reg_data;
  end

  assign bus.bus_req      = (state == ACCESS);
  assign bus.bus_wr       = wr_q;
  assign bus.bus_adr      = adr_q;
  assign bus.bus_data_out = (state == ACCESS && wr_q) ? data_q[byte_sel +: 8] : 8'h00;
  assign busy             = (state != IDLE);
  assign done             = (state == FINISH);
  assign aborted          = aborted_q;

endmodule

// File: tb/tb_wf68k30l_movep_bus_seq.sv
// Directed bench for the MOVEP byte sequencer with a scoreboard of expected bus cycles.
module tb_wf68k30l_movep_bus_seq;
  logic        clk = 1'b0;
  logic        reset_cpu, start, dir_rd, size_long;
  logic [31:0] base_adr, reg_data;
  logic [1:0]  byte_pntr;
  logic [31:0] result;
  logic        busy, done, aborted;

  wf68k30l_movep_bus_seq_if bif ();

  wf68k30l_movep_bus_seq #(.ADR_STEP(2)) dut (
    .clk(clk), .reset_cpu(reset_cpu), .start(start), .dir_rd(dir_rd),
    .size_long(size_long), .base_adr(base_adr), .reg_data(reg_data),
    .bus(bif.master), .byte_pntr(byte_pntr), .result(result),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] adr;
    logic        wr;
    logic [7:0]  data;
    logic [1:0]  pntr;
  } cyc_t;

  cyc_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic rd, input logic lng, input logic [31:0] base,
                          input logic [31:0] data);
    int n;
    cyc_t e;
    n = lng ? 4 : 2;
    for (int i = 0; i < n; i++) begin
      e.adr  = base + 32'(2 * i);
      e.pntr = 2'(n - 1 - i);
      e.data = 8'(data >> (8 * (n - 1 - i)));
      e.wr   = ~rd;
      sb.push_back(e);
    end
    dir_rd = rd; size_long = lng; base_adr = base; reg_data = data; start = 1'b1;
    tick();
    start = 1'b0;
    chk("req_one_cycle_after_start", {31'd0, bif.bus_req}, 32'd1);
    chk("busy_in_access", {31'd0, busy}, 32'd1);
  endtask

  task automatic serve(input logic [7:0] rdata, input int waits, input logic err,
                       input logic poke);
    int   n;
    cyc_t e;
    logic [31:0] adr0;
    logic [7:0]  dat0;
    n = 0;
    while (!bif.bus_req && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", {31'd0, bif.bus_req}, 32'd1);
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL sb_underflow observed=unexpected_cycle expected=no_cycle");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("bus_adr", bif.bus_adr, e.adr);
      chk("bus_wr", {31'd0, bif.bus_wr}, {31'd0, e.wr});
      chk("byte_pntr", {30'd0, byte_pntr}, {30'd0, e.pntr});
      if (e.wr) chk("bus_data_out", {24'd0, bif.bus_data_out}, {24'd0, e.data});
    end
    chk("no_done_in_access", {31'd0, done}, 32'd0);
    adr0 = bif.bus_adr;
    dat0 = bif.bus_data_out;
    for (int w = 0; w < waits; w++) begin
      if (poke) begin
        start = 1'b1; dir_rd = ~dir_rd; size_long = ~size_long;
        base_adr = 32'h9000_0000 + 32'(w); reg_data = 32'hFFFF_FFFF;
      end
      tick();
      start = 1'b0;
      chk("stall_req", {31'd0, bif.bus_req}, 32'd1);
      chk("stall_adr", bif.bus_adr, adr0);
      chk("stall_data", {24'd0, bif.bus_data_out}, {24'd0, dat0});
    end
    bif.bus_data_in = rdata; bif.bus_rdy = 1'b1; bif.bus_err = err;
    tick();
    bif.bus_rdy = 1'b0; bif.bus_err = 1'b0; bif.bus_data_in = 8'h00;
    chk("req_low_after_cycle", {31'd0, bif.bus_req}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_cpu = 1'b1; start = 1'b0; dir_rd = 1'b0; size_long = 1'b0;
    base_adr = 32'd0; reg_data = 32'd0;
    bif.bus_rdy = 1'b0; bif.bus_err = 1'b0; bif.bus_data_in = 8'h00;
    tick(); tick();
    reset_cpu = 1'b0;
    chk("rst_req", {31'd0, bif.bus_req}, 32'd0);
    chk("rst_wr", {31'd0, bif.bus_wr}, 32'd0);
    chk("rst_adr", bif.bus_adr, 32'd0);
    chk("rst_data_out", {24'd0, bif.bus_data_out}, 32'd0);
    chk("rst_pntr", {30'd0, byte_pntr}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy_done_abort", {29'd0, busy, done, aborted}, 32'd0);

    // long write
    do_start(1'b0, 1'b1, 32'h0000_1000, 32'h1122_3344);
    for (int i = 0; i < 4; i++) serve(8'h00, 0, 1'b0, 1'b0);
    chk("lw_done", {31'd0, done}, 32'd1);
    chk("lw_result_untouched", result, 32'd0);
    tick();
    chk("lw_done_pulse", {30'd0, done, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lw_no_extra_req", {31'd0, bif.bus_req}, 32'd0);
    end
    chk("lw_sb_empty", 32'(sb.size()), 32'd0);

    // word read
    do_start(1'b1, 1'b0, 32'h0000_2000, 32'hAAAA_5555);
    serve(8'h12, 0, 1'b0, 1'b0);
    serve(8'h34, 0, 1'b0, 1'b0);
    chk("wr_done", {31'd0, done}, 32'd1);
    chk("wr_result", result, 32'hAAAA_1234);
    tick();
    chk("wr_result_hold", result, 32'hAAAA_1234);

    // long read across address wrap
    do_start(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0);
    serve(8'h01, 0, 1'b0, 1'b0);
    serve(8'h02, 0, 1'b0, 1'b0);
    serve(8'h03, 0, 1'b0, 1'b0);
    serve(8'h04, 0, 1'b0, 1'b0);
    chk("wrap_done", {31'd0, done}, 32'd1);
    chk("wrap_result", result, 32'h0102_0304);
    tick();

    // bus error on second byte, RDY asserted at the same time
    do_start(1'b1, 1'b1, 32'h0000_3000, 32'h5566_7788);
    serve(8'h9A, 0, 1'b0, 1'b0);
    serve(8'h77, 0, 1'b1, 1'b0);
    sb.delete();
    chk("err_aborted", {31'd0, aborted}, 32'd1);
    chk("err_no_done", {31'd0, done}, 32'd0);
    chk("err_idle", {31'd0, busy}, 32'd0);
    chk("err_result_hi", {24'd0, result[31:24]}, 32'h9A);
    tick();
    chk("err_abort_pulse", {30'd0, aborted, done}, 32'd0);
    chk("err_req_stays_low", {31'd0, bif.bus_req}, 32'd0);

    // stalled word write with START pulses during the stall
    do_start(1'b0, 1'b0, 32'h0000_4000, 32'h0000_BEEF);
    serve(8'h00, 5, 1'b0, 1'b1);
    serve(8'h00, 0, 1'b0, 1'b0);
    chk("stall_done", {31'd0, done}, 32'd1);
    chk("stall_result_kept", {24'd0, result[31:24]}, 32'h9A);
    tick();
    chk("stall_no_restart", {31'd0, busy}, 32'd0);

    // reset after the first byte of a long write
    do_start(1'b0, 1'b1, 32'h0000_5000, 32'hCAFE_F00D);
    serve(8'h00, 0, 1'b0, 1'b0);
    reset_cpu = 1'b1;
    tick();
    reset_cpu = 1'b0;
    sb.delete();
    chk("mid_rst_req", {31'd0, bif.bus_req}, 32'd0);
    chk("mid_rst_adr", bif.bus_adr, 32'd0);
    chk("mid_rst_wr_pntr", {29'd0, bif.bus_wr, byte_pntr}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_flags", {29'd0, busy, done, aborted}, 32'd0);
    tick();
    chk("mid_rst_stays_idle", {30'd0, bif.bus_req, busy}, 32'd0);

    do_start(1'b0, 1'b1, 32'h0000_6000, 32'h0102_A0B0);
    for (int i = 0; i < 4; i++) serve(8'h00, 0, 1'b0, 1'b0);
    chk("post_rst_done", {31'd0, done}, 32'd1);
    chk("post_rst_sb_empty", 32'(sb.size()), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
